// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, synchronizer depth and SPI mode constants shared by the SPI link.
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_t;
  localparam int SPI_SYNC_STAGES = 2;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-FF synchronizer plus history FF giving level, rise and fall pulses.
module sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SPI_SYNC_STAGES-1:0] r_sync;
  logic r_hist;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SPI_SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SPI_SYNC_STAGES-2:0], i_d};
      r_hist <= r_sync[SPI_SYNC_STAGES-1];
    end
  end
  assign o_level = r_sync[SPI_SYNC_STAGES-1];
  assign o_rise  = r_sync[SPI_SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SPI_SYNC_STAGES-1] & r_hist;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 slave with one-deep TX holding buffer and RX valid pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int frame_length_MOSI = 4,
  parameter int frame_length_MISO = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         SS_n,
  input  logic                         MOSI,
  output logic                         MISO,
  output logic                         MISO_en,
  input  logic [frame_length_MISO-1:0] DATA_tx,
  input  logic                         tx_load,
  output logic                         tx_ready,
  output logic [frame_length_MOSI-1:0] DATA_rx,
  output logic                         rx_valid,
  output logic                         tx_underrun,
  output logic                         frame_error
);
  localparam int ML = frame_length_MOSI;
  localparam int SL = frame_length_MISO;
  localparam int FRAME_BITS = (ML > SL) ? ML : SL;
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FB_C = CW'(FRAME_BITS);
  localparam logic [CW-1:0] ML_C = CW'(ML);

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
  logic w_sclk_lvl, w_ss_lvl, w_mosi_rise, w_mosi_fall;
  logic [SL-1:0] w_tx_shl;
  logic [ML-1:0] w_rx_shl;

  spi_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [ML-1:0] r_rx_sh;
  logic [SL-1:0] r_tx_sh;
  logic [SL-1:0] r_buf;

  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .i_clk(clk_in), .i_rst_n(rst_n), .i_d(SCLK),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_ss (
    .i_clk(clk_in), .i_rst_n(rst_n), .i_d(SS_n),
    .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .i_clk(clk_in), .i_rst_n(rst_n), .i_d(MOSI),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_tx_shl = r_tx_sh << 1;
  assign w_rx_shl = (r_rx_sh << 1) | ML'(w_mosi);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_buf       <= '0;
      MISO        <= 1'b0;
      MISO_en     <= 1'b0;
      tx_ready    <= 1'b1;
      DATA_rx     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
      if (tx_load && tx_ready) begin
        r_buf    <= DATA_tx;
        tx_ready <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_ss_fall) begin
          r_state     <= ACTIVE;
          MISO_en     <= 1'b1;
          r_cnt       <= '0;
          r_rx_sh     <= '0;
          r_tx_sh     <= tx_ready ? '0 : r_buf;
          MISO        <= ~tx_ready & r_buf[SL-1];
          tx_underrun <= tx_ready;
          if (!tx_ready) tx_ready <= 1'b1;
        end
        ACTIVE: begin
          // SS_n rise takes priority over any SCLK edge seen in the same cycle
          if (w_ss_rise) r_state <= DONE;
          else if (w_sclk_rise && r_cnt < FB_C) begin
            if (r_cnt < ML_C) r_rx_sh <= w_rx_shl;
            r_cnt <= r_cnt + CW'(1);
          end else if (w_sclk_fall) begin
            if (r_cnt < FB_C) begin
              r_tx_sh <= w_tx_shl;
              MISO    <= w_tx_shl[SL-1];
            end else MISO <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          MISO_en <= 1'b0;
          MISO    <= 1'b0;
          if (r_cnt == FB_C) begin
            DATA_rx  <= r_rx_sh;
            rx_valid <= 1'b1;
          end else frame_error <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized scoreboard bench driving a 4/4 and an 8/4 slave from one SPI bus.
module tb_spi_slave;
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } evt_t;

  logic clk_in = 0, rst_n = 0, SCLK = 0, SS_n = 1, MOSI = 0, tx_load = 0;
  logic [3:0] DATA_tx = 0;
  logic miso0, en0, rdy0, rv0, un0, fe0;
  logic miso1, en1, rdy1, rv1, un1, fe1;
  logic [3:0] drx0;
  logic [7:0] drx1;

  int tests = 0, fails = 0;
  evt_t q0[$], q1[$];
  logic model_ready = 1;
  logic [3:0] model_buf = 0;
  logic [7:0] exp_drx0 = 0, exp_drx1 = 0;

  always #5 clk_in = ~clk_in;

  spi_slave #(.frame_length_MOSI(4), .frame_length_MISO(4)) u4 (
    .clk_in(clk_in), .rst_n(rst_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso0), .MISO_en(en0), .DATA_tx(DATA_tx), .tx_load(tx_load),
    .tx_ready(rdy0), .DATA_rx(drx0), .rx_valid(rv0), .tx_underrun(un0), .frame_error(fe0)
  );
  spi_slave #(.frame_length_MOSI(8), .frame_length_MISO(4)) u8 (
    .clk_in(clk_in), .rst_n(rst_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso1), .MISO_en(en1), .DATA_tx(DATA_tx), .tx_load(tx_load),
    .tx_ready(rdy1), .DATA_rx(drx1), .rx_valid(rv1), .tx_underrun(un1), .frame_error(fe1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 underrun, 1 rx_valid with data, 2 frame_error, 3 illegal combination
  task automatic mon(input int inst, input logic rv, input logic fe, input logic un, input logic [7:0] d);
    evt_t e;
    logic [1:0] k;
    if (rv | fe | un) begin
      k = un ? 2'd0 : (rv ? 2'd1 : 2'd2);
      if (int'(rv) + int'(fe) + int'(un) > 1) k = 2'd3;
      if ((inst == 0 ? q0.size() : q1.size()) == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse inst=%0d actual kind=%0d required none", inst, k);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        chk(inst == 0 ? "evt_kind4" : "evt_kind8", k, e.kind);
        if (e.kind == 2'd1) chk(inst == 0 ? "rx_data4" : "rx_data8", d, e.data);
      end
    end
  endtask

  always @(negedge clk_in) if (rst_n) begin
    mon(0, rv0, fe0, un0, {4'b0, drx0});
    mon(1, rv1, fe1, un1, drx1);
  end

  task automatic load(input logic [3:0] d);
    DATA_tx = d;
    tx_load = 1;
    @(negedge clk_in);
    tx_load = 0;
    if (model_ready) begin
      model_buf = d;
      model_ready = 0;
    end
    chk("tx_ready4_load", rdy0, model_ready);
    chk("tx_ready8_load", rdy1, model_ready);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_miso4"}, miso0, 0);
    chk({tag, "_miso8"}, miso1, 0);
    chk({tag, "_en4"}, en0, 0);
    chk({tag, "_en8"}, en1, 0);
    chk({tag, "_rdy"}, rdy0 & rdy1 | ~(rdy0 | rdy1) ? {31'b0, rdy0} : 32'hx, model_ready);
    chk({tag, "_drx4"}, drx0, exp_drx0[3:0]);
    chk({tag, "_drx8"}, drx1, exp_drx1);
  endtask

  // n SCLK rise/fall pairs carrying mo MSB first; rst_at >= 0 resets the DUTs before that bit
  task automatic frame(input int n, input logic [7:0] mo, input int rst_at);
    logic und;
    logic [3:0] w;
    logic exp_bit;
    und = model_ready;
    w = model_buf;
    if (und) begin
      q0.push_back('{2'd0, 8'h0});
      q1.push_back('{2'd0, 8'h0});
    end
    model_ready = 1;
    SS_n = 0;
    repeat (6) @(negedge clk_in);
    chk("miso_en4_active", en0, 1);
    chk("miso_en8_active", en1, 1);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 0;
        SS_n = 1;
        SCLK = 0;
        q0.delete();
        q1.delete();
        model_ready = 1;
        exp_drx0 = 0;
        exp_drx1 = 0;
        repeat (3) @(negedge clk_in);
        idle_checks("midreset");
        chk("midreset_pulses", {rv0, un0, fe0, rv1, un1, fe1}, 0);
        rst_n = 1;
        repeat (6) @(negedge clk_in);
        return;
      end
      MOSI = mo[7-i];
      repeat (4) @(negedge clk_in);
      exp_bit = (!und && i < 4) ? w[3-i] : 1'b0;
      chk("miso4_bit", miso0, exp_bit);
      chk("miso8_bit", miso1, exp_bit);
      SCLK = 1;
      repeat (4) @(negedge clk_in);
      SCLK = 0;
    end
    repeat (6) @(negedge clk_in);
    if (n >= 4) begin
      exp_drx0 = {4'b0, mo[7:4]};
      q0.push_back('{2'd1, exp_drx0});
    end else q0.push_back('{2'd2, 8'h0});
    if (n >= 8) begin
      exp_drx1 = mo;
      q1.push_back('{2'd1, exp_drx1});
    end else q1.push_back('{2'd2, 8'h0});
    SS_n = 1;
    repeat (10) @(negedge clk_in);
    idle_checks("post_frame");
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    idle_checks("reset");
    chk("reset_pulses", {rv0, un0, fe0, rv1, un1, fe1}, 0);
    rst_n = 1;
    repeat (5) @(negedge clk_in);
    load(4'hA);
    frame(4, 8'b0110_0000, -1);
    frame(4, 8'h90, -1);
    frame(2, 8'hC0, -1);
    load(4'hC);
    frame(8, 8'hA5, -1);
    load(4'h3);
    load(4'hF);
    frame(4, 8'h5A, -1);
    for (int r = 0; r < 12; r++) begin
      int n;
      if ($urandom_range(1) == 1) load(4'($urandom));
      n = $urandom_range(9, 1);
      frame(n, 8'($urandom), -1);
    end
    load(4'h5);
    frame(8, 8'h3C, 2);
    load(4'h6);
    frame(8, 8'($urandom), -1);
    chk("q4_drained", q0.size(), 0);
    chk("q8_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
